alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_pkg.sv | 19 +
 rtl/alu_seq_ctrl_debounce.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 74 +++++++
 tb/tb_alu_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the step-driven ALU sequencer: state codes,
// display selector codes and the default datapath width.
package alu_seq_ctrl_pkg;
  localparam int X_LEN_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    EXEC    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] SEL_BLANK = 2'b00;
  localparam logic [1:0] SEL_A     = 2'b01;
  localparam logic [1:0] SEL_B     = 2'b10;
  localparam logic [1:0] SEL_F     = 2'b11;
endpackage

// File: rtl/alu_seq_ctrl_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-count debounce and a
// single-cycle pulse on each accepted rising level.
module step_debounce #(
  parameter int DB_CNT = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse_out
);
  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic          s0, s1, lvl;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      lvl       <= 1'b0;
      cnt       <= '0;
      pulse_out <= 1'b0;
    end else begin
      s0        <= btn_in;
      s1        <= s0;
      pulse_out <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (s1 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        lvl       <= s1;
        pulse_out <= s1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Step-by-step ALU front end: latches A, B and opcode from the switch bank on
// debounced button presses, then captures the ALU result and flags.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int X_LEN  = X_LEN_DEF,
  parameter int DB_CNT = 400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [X_LEN-1:0] sw,
  input  logic [X_LEN-1:0] alu_f,
  input  logic [3:0]       alu_flags,
  output logic [X_LEN-1:0] a_q,
  output logic [X_LEN-1:0] b_q,
  output logic [3:0]       op_q,
  output logic [X_LEN-1:0] f_q,
  output logic [3:0]       fr_q,
  output logic [1:0]       out_sel,
  output logic [2:0]       state_q,
  output logic             done
);
  state_t state;
  logic   step_pulse;

  step_debounce #(.DB_CNT(DB_CNT)) u_db (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (step),
    .pulse_out(step_pulse)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      f_q   <= '0;
      fr_q  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (step_pulse) state <= LOAD_A;
        LOAD_A:  if (step_pulse) begin a_q  <= sw;      state <= LOAD_B;  end
        LOAD_B:  if (step_pulse) begin b_q  <= sw;      state <= LOAD_OP; end
        LOAD_OP: if (step_pulse) begin op_q <= sw[3:0]; state <= EXEC;    end
        // One cycle for the external ALU to settle on the new operands.
        EXEC: begin
          f_q   <= alu_f;
          fr_q  <= alu_flags;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    if (step_pulse) state <= LOAD_A;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_q = state;

  always_comb begin
    out_sel = SEL_BLANK;
    case (state)
      LOAD_A:          out_sel = SEL_A;
      LOAD_B, LOAD_OP: out_sel = SEL_B;
      EXEC, DONE:      out_sel = SEL_F;
      default:         out_sel = SEL_BLANK;
    endcase
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl with an adder ALU stub and a press-level
// reference model.
module tb_alu_seq_ctrl;
  localparam int XL = 32;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step = 1'b0;
  logic [XL-1:0] sw = '0;
  logic [XL-1:0] alu_f;
  logic [3:0]    alu_flags;
  logic [XL-1:0] a_q, b_q, f_q;
  logic [3:0]    op_q, fr_q;
  logic [1:0]    out_sel;
  logic [2:0]    state_q;
  logic          done;

  alu_seq_ctrl #(.X_LEN(XL), .DB_CNT(DB)) dut (
    .clk(clk), .rst(rst), .step(step), .sw(sw),
    .alu_f(alu_f), .alu_flags(alu_flags),
    .a_q(a_q), .b_q(b_q), .op_q(op_q), .f_q(f_q), .fr_q(fr_q),
    .out_sel(out_sel), .state_q(state_q), .done(done)
  );

  assign alu_f     = a_q + b_q;
  assign alu_flags = {(alu_f == '0), 3'b000};

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, exec_cyc = -1, done_cyc = -1, done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && state_q == 3'd4) exec_cyc <= cyc;
    if (rst && done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  // reference model, advanced once per accepted press
  int            m_st;
  logic [XL-1:0] m_a, m_b, m_f;
  logic [3:0]    m_op, m_fr;
  int            m_done;
  int            sel_tab [6] = '{0, 1, 2, 2, 3, 3};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_a = '0; m_b = '0; m_f = '0; m_op = '0; m_fr = '0;
  endtask

  task automatic model_press(input logic [XL-1:0] v);
    case (m_st)
      0: m_st = 1;
      1: begin m_a = v; m_st = 2; end
      2: begin m_b = v; m_st = 3; end
      3: begin
        m_op = v[3:0];
        m_f  = m_a + m_b;
        m_fr = {(m_f == '0), 3'b000};
        m_st = 5;
        m_done++;
      end
      default: m_st = 1;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 64'(state_q), 64'(m_st));
    chk({tag, ".a"},     64'(a_q),     64'(m_a));
    chk({tag, ".b"},     64'(b_q),     64'(m_b));
    chk({tag, ".op"},    64'(op_q),    64'(m_op));
    chk({tag, ".f"},     64'(f_q),     64'(m_f));
    chk({tag, ".fr"},    64'(fr_q),    64'(m_fr));
    chk({tag, ".sel"},   64'(out_sel), 64'(sel_tab[m_st]));
    chk({tag, ".dones"}, 64'(done_cnt), 64'(m_done));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold step high for hi cycles then low long enough to settle.
  task automatic press(input int hi, input logic [XL-1:0] v);
    int st0;
    st0 = m_st;
    sw   = v;
    step = 1'b1;
    cycles(hi);
    step = 1'b0;
    cycles(12);
    if (hi >= DB) begin
      model_press(v);
      if (st0 == 3) chk("latency", 64'(done_cyc - exec_cyc), 64'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    step = 1'b0;
    #1;
    model_reset();
    chk("rst.done", 64'(done), 64'd0);
    check_all("rst");
    cycles(3);
    rst = 1'b1;
    cycles(2);
  endtask

  initial begin
    logic [XL-1:0] v;
    int hi;
    bit hit;
    m_done = 0;
    model_reset();
    cycles(3);
    check_all("por");
    rst = 1'b1;
    cycles(2);

    // clean sequence: A=5, B=3, op=1
    press(8, 32'd0); check_all("seq.idle");
    press(8, 32'd5); check_all("seq.a");
    press(8, 32'd3); check_all("seq.b");
    press(8, 32'd1); check_all("seq.exec");

    // short glitches ignored, longer one advances once
    for (int g = 1; g <= 3; g++) begin
      press(g, 32'hdead);
      check_all("glitch");
    end
    press(6, 32'hbeef); check_all("glitch6");

    // long hold in LOAD_A captures once
    press(100, 32'h1234_5678); check_all("hold100");

    // A=B=0: zero flag, then next press back to LOAD_A with f held
    do_reset();
    press(5, 32'd0); press(5, 32'd0); press(5, 32'd0);
    press(5, 32'd7); check_all("zero");
    press(5, 32'd9); check_all("zero.next");

    // randomized presses, some below the debounce threshold
    for (int i = 0; i < 40; i++) begin
      hi = int'($urandom_range(1, 9));
      v  = $urandom();
      press(hi, v);
      check_all("rand");
    end

    // reset during EXEC aborts the capture
    do_reset();
    press(6, $urandom()); press(6, $urandom()); press(6, $urandom());
    sw = $urandom(); step = 1'b1; hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (state_q == 3'd4) hit = 1'b1;
    end
    chk("exec.reached", 64'(hit), 64'd1);
    rst = 1'b0;
    step = 1'b0;
    #1;
    model_reset();
    check_all("exec.abort");
    cycles(3);
    rst = 1'b1;
    cycles(12);
    check_all("exec.idle");

    // step held high across reset release
    @(negedge clk);
    rst = 1'b0;
    step = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    check_all("held.early");
    cycles(8);
    step = 1'b0;
    cycles(12);
    model_press('0);
    check_all("held.late");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout got %0d exp %0d", cyc, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
